// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand-forwarding selects, load-use stall and
// taken-branch flush control for the 5-stage core, plus a stall counter.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   id_*                decode-stage instruction fields
//   ex_branch_taken     EX resolved a taken branch/jump this cycle
//   fwd_a_sel/fwd_b_sel 00 regfile, 01 EX/MEM result, 10 MEM/WB value
//   pc_stall/ifid_stall hold PC and IF/ID on a load-use hazard
//   idex_bubble         insert a NOP into ID/EX
//   ifid_flush          squash IF/ID on a taken branch
//   stall_count         saturating count of load-use stall cycles
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              mem_read;
    } idex_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
    } wb_t;

    idex_t idex_q, idex_d;
    wb_t   exmem_q, exmem_d;
    wb_t   memwb_q, memwb_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       luh;
    logic       stall_raw;
    logic       bubble_raw;
    logic       flush_raw;
    logic [1:0] sel_a_raw;
    logic [1:0] sel_b_raw;

    // The EX/MEM producer is younger than MEM/WB, so it wins.
    // x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic              use_rs,
        input logic [REG_AW-1:0] rs,
        input wb_t               em,
        input wb_t               mw
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (use_rs && em.we && (em.rd != '0) && (em.rd == rs)) begin
            sel = SEL_MEM;
        end else if (mw.we && (mw.rd != '0) && (mw.rd == rs)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        sel_a_raw = fwd_sel(idex_q.use_rs1, idex_q.rs1, exmem_q, memwb_q);
        sel_b_raw = fwd_sel(idex_q.use_rs2, idex_q.rs2, exmem_q, memwb_q);
    end

    // Load in EX whose result a real ID consumer needs right now.
    always_comb begin
        luh = idex_q.valid
            & idex_q.mem_read
            & (idex_q.rd != '0)
            & id_valid
            & ((id_use_rs1 & (id_rs1 == idex_q.rd))
             | (id_use_rs2 & (id_rs2 == idex_q.rd)));
    end

    // A taken branch squashes the stalled consumer, so it overrides
    // the stall: only the flush and bubble remain.
    always_comb begin
        flush_raw  = ex_branch_taken;
        stall_raw  = luh & ~ex_branch_taken;
        bubble_raw = luh | ex_branch_taken;
    end

    always_comb begin
        idex_d = '0;
        if (!bubble_raw) begin
            idex_d.valid    = id_valid;
            idex_d.rs1      = id_rs1;
            idex_d.rs2      = id_rs2;
            idex_d.use_rs1  = id_use_rs1;
            idex_d.use_rs2  = id_use_rs2;
            idex_d.rd       = id_rd;
            idex_d.we       = id_reg_write & id_valid;
            idex_d.mem_read = id_mem_read & id_valid;
        end
    end

    always_comb begin
        exmem_d    = '0;
        exmem_d.rd = idex_q.rd;
        exmem_d.we = idex_q.we & idex_q.valid;
        memwb_d    = exmem_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_raw && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gate with rst so control drops the moment reset asserts, even
    // while ex_branch_taken is still high.
    always_comb begin
        fwd_a_sel   = rst ? SEL_RF : sel_a_raw;
        fwd_b_sel   = rst ? SEL_RF : sel_b_raw;
        pc_stall    = stall_raw & ~rst;
        ifid_stall  = stall_raw & ~rst;
        idex_bubble = bubble_raw & ~rst;
        ifid_flush  = flush_raw & ~rst;
        stall_count = cnt_q;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed vector table, reset and
// saturation sequences, and random stimulus against a pipeline model.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_reg_write, id_mem_read;
    logic       ex_branch_taken;

    logic [1:0]  fa, fb, fa2, fb2;
    logic        pcs, ifs, bub, fl;
    logic        pcs2, ifs2, bub2, fl2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel(fa), .fwd_b_sel(fb), .pc_stall(pcs),
        .ifid_stall(ifs), .idex_bubble(bub), .ifid_flush(fl),
        .stall_count(cnt)
    );

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel(fa2), .fwd_b_sel(fb2), .pc_stall(pcs2),
        .ifid_stall(ifs2), .idex_bubble(bub2), .ifid_flush(fl2),
        .stall_count(cnt2)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       we, mr, br;
        logic [1:0] ea, eb;
        logic       pcs, ifs, bub, fl;
        int         cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input int rs1, input int rs2,
        input logic u1, input logic u2, input int rd,
        input logic we, input logic mr, input logic br,
        input int ea, input int eb, input logic p, input logic i,
        input logic b, input logic f, input int c
    );
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
        r.u1 = u1; r.u2 = u2; r.rd = 5'(rd);
        r.we = we; r.mr = mr; r.br = br;
        r.ea = 2'(ea); r.eb = 2'(eb);
        r.pcs = p; r.ifs = i; r.bub = b; r.fl = f; r.cnt = c;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u1,
                         input logic u2, input logic [4:0] rd,
                         input logic we, input logic mr,
                         input logic br);
        id_valid = v; id_rs1 = r1; id_rs2 = r2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = rd;
        id_reg_write = we; id_mem_read = mr; ex_branch_taken = br;
    endtask

    // ---------------- behavioural pipeline model ----------------
    // Slot 0 = instruction in EX, 1 = in MEM, 2 = in WB.
    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       w;
        logic       mr;
    } ins_t;

    ins_t pipe[3];
    int   m_cnt;
    int   m_cnt2;

    task automatic m_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    // Youngest older writer of a nonzero matching register supplies it.
    function automatic int m_fwd(input logic u, input logic [4:0] rs,
                                 input int is_a);
        if (is_a != 0 && !u) return 0;
        for (int k = 1; k < 3; k++) begin
            if (k == 1 && !u) continue;
            if (pipe[k].w && pipe[k].rd != 0 && pipe[k].rd == rs) return k;
        end
        return 0;
    endfunction

    function automatic logic m_luh();
        return pipe[0].v && pipe[0].mr && pipe[0].rd != 0 && id_valid &&
               ((id_use_rs1 && id_rs1 == pipe[0].rd) ||
                (id_use_rs2 && id_rs2 == pipe[0].rd));
    endfunction

    // Check both DUTs against the model, then clock and advance it.
    task automatic step_model(input string tag);
        logic h, st, bb;
        int ea, eb;
        #1;
        h  = m_luh();
        st = h && !ex_branch_taken;
        bb = h || ex_branch_taken;
        ea = m_fwd(pipe[0].u1, pipe[0].rs1, 0);
        eb = m_fwd(pipe[0].u2, pipe[0].rs2, 0);
        chk({tag, " fwd_a"}, int'(fa), ea);
        chk({tag, " fwd_b"}, int'(fb), eb);
        chk({tag, " fwd_a2"}, int'(fa2), ea);
        chk({tag, " fwd_b2"}, int'(fb2), eb);
        chk({tag, " pc_stall"}, int'(pcs), int'(st));
        chk({tag, " ifid_stall"}, int'(ifs2), int'(st));
        chk({tag, " bubble"}, int'(bub), int'(bb));
        chk({tag, " flush"}, int'(fl), int'(ex_branch_taken));
        chk({tag, " count"}, int'(cnt), m_cnt);
        chk({tag, " count2"}, int'(cnt2), m_cnt2);
        @(posedge clk);
        if (st) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (bb) begin
            pipe[0] = '{default: '0};
        end else begin
            pipe[0].v  = id_valid;
            pipe[0].rs1 = id_rs1;
            pipe[0].rs2 = id_rs2;
            pipe[0].u1 = id_use_rs1;
            pipe[0].u2 = id_use_rs2;
            pipe[0].rd = id_rd;
            pipe[0].w  = id_valid && id_reg_write;
            pipe[0].mr = id_valid && id_mem_read;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[19];
        tbl[0]  = mk(1,1,2,1,1,5,1,0,0, 0,0,0,0,0,0,0);
        tbl[1]  = mk(1,5,4,1,1,6,1,0,0, 0,0,0,0,0,0,0);
        tbl[2]  = mk(1,8,5,1,1,9,1,0,0, 1,0,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,0,0,0,0, 0,2,0,0,0,0,0);
        tbl[4]  = mk(1,1,2,1,1,7,1,0,0, 0,0,0,0,0,0,0);
        tbl[5]  = mk(1,3,4,1,1,7,1,0,0, 0,0,0,0,0,0,0);
        tbl[6]  = mk(1,7,7,1,1,10,1,0,0, 0,0,0,0,0,0,0);
        tbl[7]  = mk(1,1,1,0,0,0,1,0,0, 1,1,0,0,0,0,0);
        tbl[8]  = mk(1,0,0,1,1,11,1,0,0, 0,0,0,0,0,0,0);
        tbl[9]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        tbl[10] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        tbl[11] = mk(1,1,0,1,0,3,1,1,0, 0,0,0,0,0,0,0);
        tbl[12] = mk(1,4,3,1,1,12,1,0,0, 0,0,1,1,1,0,0);
        tbl[13] = mk(1,4,3,1,1,12,1,0,0, 0,0,0,0,0,0,1);
        tbl[14] = mk(0,0,0,0,0,0,0,0,0, 0,2,0,0,0,0,1);
        tbl[15] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1);
        tbl[16] = mk(1,1,0,1,0,3,1,1,0, 0,0,0,0,0,0,1);
        tbl[17] = mk(1,3,0,1,0,13,1,0,1, 0,0,0,0,1,1,1);
        tbl[18] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset fwd_a", int'(fa), 0);
        chk("reset bubble", int'(bub), 0);
        chk("reset count", int'(cnt), 0);
        do_reset();

        for (int i = 0; i < 19; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1,
                  tbl[i].u2, tbl[i].rd, tbl[i].we, tbl[i].mr,
                  tbl[i].br);
            #1;
            chk({nm, " fwd_a"}, int'(fa), int'(tbl[i].ea));
            chk({nm, " fwd_b"}, int'(fb), int'(tbl[i].eb));
            chk({nm, " pc_stall"}, int'(pcs), int'(tbl[i].pcs));
            chk({nm, " ifid_stall"}, int'(ifs), int'(tbl[i].ifs));
            chk({nm, " bubble"}, int'(bub), int'(tbl[i].bub));
            chk({nm, " flush"}, int'(fl), int'(tbl[i].fl));
            chk({nm, " count"}, int'(cnt), tbl[i].cnt);
            @(posedge clk);
            #1;
        end

        // Reset asserted in the middle of a load-use stall with a
        // branch arriving: every control output must drop at once.
        drive(1, 1, 0, 1, 0, 3, 1, 1, 0);
        @(posedge clk);
        #1;
        drive(1, 3, 0, 1, 0, 14, 1, 0, 0);
        #1;
        chk("pre-reset stall", int'(pcs), 1);
        ex_branch_taken = 1'b1;
        rst = 1'b1;
        #1;
        chk("midreset pc_stall", int'(pcs), 0);
        chk("midreset ifid_stall", int'(ifs), 0);
        chk("midreset bubble", int'(bub), 0);
        chk("midreset flush", int'(fl), 0);
        chk("midreset fwd_a", int'(fa), 0);
        chk("midreset count", int'(cnt), 0);
        do_reset();

        // Chains of loads feeding loads feeding an ALU op; each link
        // stalls one cycle. Six stalls saturate the 2-bit counter.
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0, 1, 0, 3, 1, 1, 0);
            step_model("chain lw3");
            drive(1, 3, 0, 1, 0, 4, 1, 1, 0);
            step_model("chain lw4 stall");
            step_model("chain lw4 go");
            drive(1, 4, 4, 1, 1, 5, 1, 0, 0);
            step_model("chain add stall");
            step_model("chain add go");
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step_model("chain nop");
        end
        chk("saturated count2", int'(cnt2), 3);
        chk("wide count", int'(cnt), 6);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(3, 0) != 0,
                  5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                  $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                  5'($urandom_range(7, 0)),
                  $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 4,
                  $urandom_range(9, 0) == 0);
            step_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
